// File: rtl/dcdl_sar_ctrl.sv
// SAR delay-code search followed by +/-1 LSB tracking and lock detection for the DLL delay line.
// Optional build macro DCDL_TRACK_FILTER_EN: tracking steps only after two matching decisions in a row.
`timescale 1ns/1ps
module dcdl_sar_ctrl #(
  parameter int CODE_W   = 10,
  parameter int COARSE_W = 4,
  parameter int SETTLE   = 3,
  parameter int LOCK_CNT = 8
) (
  input  logic                   clk_ext,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   hold,
  input  logic                   pd_lead,
  input  logic                   pd_lag,
  output logic [CODE_W-1:0]      Q,
  output logic [2**COARSE_W-1:0] T,
  output logic [2**COARSE_W-1:0] Tb,
  output logic                   busy,
  output logic                   sar_done,
  output logic                   locked,
  output logic                   err_sat
);

  localparam int TW = 2**COARSE_W;
  localparam int IW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [IW-1:0]     I_MSB  = IW'(CODE_W - 1);
  localparam logic [WW-1:0]     W_LAST = WW'(SETTLE - 1);
  localparam logic [LW-1:0]     L_MAX  = LW'(LOCK_CNT);
  localparam logic [CODE_W-1:0] Q_MAX  = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0] Q_ZERO = {CODE_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAR_SET  = 3'd1,
    S_SAR_WAIT = 3'd2,
    S_SAR_EVAL = 3'd3,
    S_TRK_WAIT = 3'd4,
    S_TRK_EVAL = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  state_t            state_r;
  logic [CODE_W-1:0] q_r;
  logic [IW-1:0]     bit_r;
  logic [WW-1:0]     wait_r;
  logic [LW-1:0]     lock_cnt_r;
  dir_t              last_dir_r;
  logic              busy_r, sar_done_r, locked_r, err_sat_r;
  dir_t              dir_raw_s, dir_s;
  logic [LW-1:0]     lock_nxt_s;
  logic              repeat_s;
`ifdef DCDL_TRACK_FILTER_EN
  dir_t              pend_r;
`endif

  assign Q        = q_r;
  assign T        = ~({TW{1'b1}} << q_r[CODE_W-1 -: COARSE_W]);
  assign Tb       = ~T;
  assign busy     = busy_r;
  assign sar_done = sar_done_r;
  assign locked   = locked_r;
  assign err_sat  = err_sat_r;

  // Raw phase-detector decision; contradictory or absent indications mean no move.
  always_comb begin
    dir_raw_s = DIR_NONE;
    if (pd_lead && !pd_lag) begin
      dir_raw_s = DIR_UP;
    end else if (pd_lag && !pd_lead) begin
      dir_raw_s = DIR_DN;
    end else begin
      dir_raw_s = DIR_NONE;
    end
  end

  // Effective tracking outcome; the filtered build needs the same direction twice in a row.
  always_comb begin
    dir_s = DIR_NONE;
`ifdef DCDL_TRACK_FILTER_EN
    if ((dir_raw_s != DIR_NONE) && (dir_raw_s == pend_r)) begin
      dir_s = dir_raw_s;
    end else begin
      dir_s = DIR_NONE;
    end
`else
    dir_s = dir_raw_s;
`endif
  end

  // Saturating lock counter candidate and repeated-direction detect.
  always_comb begin
    lock_nxt_s = lock_cnt_r;
    if (lock_cnt_r == L_MAX) begin
      lock_nxt_s = L_MAX;
    end else begin
      lock_nxt_s = lock_cnt_r + LW'(1);
    end
    repeat_s = (dir_s != DIR_NONE) && (dir_s == last_dir_r);
  end

  // Main controller FSM with all registered outputs.
  always_ff @(posedge clk_ext) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      q_r        <= Q_ZERO;
      bit_r      <= '0;
      wait_r     <= '0;
      lock_cnt_r <= '0;
      last_dir_r <= DIR_NONE;
      busy_r     <= 1'b0;
      sar_done_r <= 1'b0;
      locked_r   <= 1'b0;
      err_sat_r  <= 1'b0;
`ifdef DCDL_TRACK_FILTER_EN
      pend_r     <= DIR_NONE;
`endif
    end else if (start) begin
      state_r    <= S_SAR_SET;
      q_r        <= Q_ZERO;
      bit_r      <= I_MSB;
      wait_r     <= '0;
      lock_cnt_r <= '0;
      last_dir_r <= DIR_NONE;
      busy_r     <= 1'b1;
      sar_done_r <= 1'b0;
      locked_r   <= 1'b0;
      err_sat_r  <= 1'b0;
`ifdef DCDL_TRACK_FILTER_EN
      pend_r     <= DIR_NONE;
`endif
    end else if (hold) begin
      sar_done_r <= 1'b0;
    end else begin
      sar_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          state_r <= S_IDLE;
        end
        S_SAR_SET: begin
          q_r[bit_r] <= 1'b1;
          wait_r     <= '0;
          state_r    <= S_SAR_WAIT;
        end
        S_SAR_WAIT, S_TRK_WAIT: begin
          if (wait_r == W_LAST) begin
            wait_r  <= '0;
            state_r <= (state_r == S_SAR_WAIT) ? S_SAR_EVAL : S_TRK_EVAL;
          end else begin
            wait_r  <= wait_r + WW'(1);
          end
        end
        S_SAR_EVAL: begin
          q_r[bit_r] <= pd_lead;
          if (bit_r == IW'(0)) begin
            sar_done_r <= 1'b1;
            busy_r     <= 1'b0;
            wait_r     <= '0;
            state_r    <= S_TRK_WAIT;
          end else begin
            bit_r      <= bit_r - IW'(1);
            state_r    <= S_SAR_SET;
          end
        end
        S_TRK_EVAL: begin
          case (dir_s)
            DIR_UP: begin
              if (q_r == Q_MAX) err_sat_r <= 1'b1;
              else              q_r       <= q_r + CODE_W'(1);
            end
            DIR_DN: begin
              if (q_r == Q_ZERO) err_sat_r <= 1'b1;
              else               q_r       <= q_r - CODE_W'(1);
            end
            default: q_r <= q_r;
          endcase
          if (repeat_s) begin
            lock_cnt_r <= '0;
            locked_r   <= 1'b0;
          end else begin
            lock_cnt_r <= lock_nxt_s;
            locked_r   <= (lock_nxt_s == L_MAX);
          end
          if (dir_s != DIR_NONE) last_dir_r <= dir_s;
          else                   last_dir_r <= last_dir_r;
`ifdef DCDL_TRACK_FILTER_EN
          if (dir_s != DIR_NONE) pend_r <= DIR_NONE;
          else                   pend_r <= dir_raw_s;
`endif
          wait_r  <= '0;
          state_r <= S_TRK_WAIT;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcdl_sar_ctrl.sv
// Self-checking bench for dcdl_sar_ctrl: behavioural phase-detector plus SAR/tracking/lock reference model.
`timescale 1ns/1ps
module tb_dcdl_sar_ctrl;
  localparam int CODE_W = 10, COARSE_W = 4, SETTLE = 3, LOCK_CNT = 8, TW = 16;

  logic clk_ext = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
  logic pd_lead, pd_lag;
  logic [CODE_W-1:0] Q;
  logic [TW-1:0] T, Tb;
  logic busy, sar_done, locked, err_sat;

  int target = 677;
  bit force_lead = 1'b0;
  int checks = 0, failures = 0;
  int m_q, m_cnt, m_last;
  bit m_err, m_locked;

  dcdl_sar_ctrl #(.CODE_W(CODE_W), .COARSE_W(COARSE_W), .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_ext(clk_ext), .rst_n(rst_n), .start(start), .hold(hold),
    .pd_lead(pd_lead), .pd_lag(pd_lag), .Q(Q), .T(T), .Tb(Tb),
    .busy(busy), .sar_done(sar_done), .locked(locked), .err_sat(err_sat));

  always #5 clk_ext = ~clk_ext;

  // Ideal phase detector: aligned point sits at 'target'.
  assign pd_lead = force_lead | (int'(Q) <= target);
  assign pd_lag  = ~force_lead & (int'(Q) > target);

  function automatic int sar_ref(input int tgt, input int lowest);
    int code = 0;
    for (int b = CODE_W - 1; b >= lowest; b--)
      if (code + (1 << b) <= tgt) code += (1 << b);
    return code;
  endfunction

  function automatic logic [TW-1:0] therm(input int code);
    logic [TW-1:0] t = '0;
    int coarse = code >> (CODE_W - COARSE_W);
    for (int k = 0; k < TW; k++) t[k] = (k < coarse);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk_ext); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (sar_done !== 1'b1 && n < 300) begin tick(); n++; end
  endtask

  task automatic model_init();
    m_q = sar_ref(target, 0); m_cnt = 0; m_last = 0; m_err = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_eval();
    bit lead, lag; int d;
    lead = force_lead || (m_q <= target);
    lag  = !force_lead && (m_q > target);
    d = (lead && !lag) ? 1 : ((lag && !lead) ? 2 : 0);
    if (d == 1) begin if (m_q == (1 << CODE_W) - 1) m_err = 1'b1; else m_q++; end
    if (d == 2) begin if (m_q == 0) m_err = 1'b1; else m_q--; end
    if (d != 0 && d == m_last) m_cnt = 0;
    else m_cnt = (m_cnt < LOCK_CNT) ? m_cnt + 1 : LOCK_CNT;
    if (d != 0) m_last = d;
    m_locked = (m_cnt == LOCK_CNT);
  endtask

  task automatic track_evals(input int n);
    for (int e = 0; e < n; e++) begin
      for (int c = 0; c < SETTLE + 1; c++) begin
        tick();
        checks++; if (sar_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL trk_flags: sar_done=%b busy=%b expected 0/0", sar_done, busy); end
      end
      model_eval();
      checks++; if (Q !== CODE_W'(m_q)) begin failures++; $display("FAIL trk_q: got %0d expected %0d", Q, m_q); end
      checks++; if (locked !== m_locked) begin failures++; $display("FAIL trk_locked: got %b expected %b (eval %0d)", locked, m_locked, e); end
      checks++; if (err_sat !== m_err) begin failures++; $display("FAIL trk_err_sat: got %b expected %b", err_sat, m_err); end
      checks++; if (T !== therm(m_q)) begin failures++; $display("FAIL trk_T: got %h expected %h", T, therm(m_q)); end
    end
  endtask

  task automatic check_sar(input int n, input int n_exp);
    int exp_q = sar_ref(target, 0);
    checks++; if (n !== n_exp) begin failures++; $display("FAIL sar_latency: got %0d expected %0d", n, n_exp); end
    checks++; if (Q !== CODE_W'(exp_q)) begin failures++; $display("FAIL sar_q: got %h expected %h", Q, exp_q); end
    checks++; if (T !== therm(exp_q) || Tb !== ~therm(exp_q)) begin failures++; $display("FAIL sar_T: got %h/%h expected %h", T, Tb, therm(exp_q)); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sar_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    checks++; if (Q !== 10'h000) begin failures++; $display("FAIL rst_q: got %h expected 000", Q); end
    checks++; if (T !== 16'h0000 || Tb !== 16'hFFFF) begin failures++; $display("FAIL rst_T: got %h/%h expected 0000/ffff", T, Tb); end
    checks++; if ({busy, locked, err_sat, sar_done} !== 4'b0000) begin failures++; $display("FAIL rst_flags: got %b expected 0000", {busy, locked, err_sat, sar_done}); end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_sar_track();
    int n;
    target = 677; pulse_start();
    checks++; if (busy !== 1'b1 || Q !== 10'h000) begin failures++; $display("FAIL start_state: busy=%b Q=%h expected 1/000", busy, Q); end
    wait_done(n);
    check_sar(n, 50);
    checks++; if (Q !== 10'h2A5 || T !== 16'h03FF) begin failures++; $display("FAIL sar_677: got %h/%h expected 2a5/03ff", Q, T); end
    model_init();
    track_evals(7);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early: got %b expected 0", locked); end
    track_evals(1);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_8th: got %b expected 1", locked); end
    track_evals(2);
    force_lead = 1'b1;
    track_evals(2);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_drop: got %b expected 0", locked); end
    force_lead = 1'b0;
  endtask

  task automatic test_saturation();
    int n;
    target = 1023; pulse_start(); wait_done(n);
    check_sar(n, 50);
    model_init(); track_evals(1);
    checks++; if (err_sat !== 1'b1 || Q !== 10'h3FF) begin failures++; $display("FAIL sat: err=%b Q=%h expected 1/3ff", err_sat, Q); end
    pulse_start();
    checks++; if (err_sat !== 1'b0 || Q !== 10'h000 || busy !== 1'b1) begin failures++; $display("FAIL sat_clear: err=%b Q=%h busy=%b expected 0/000/1", err_sat, Q, busy); end
  endtask

  task automatic test_hold();
    int n, q_trial;
    target = 677; pulse_start();
    repeat (16) tick();
    q_trial = sar_ref(target, 7) + 64;
    hold = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (Q !== CODE_W'(q_trial) || busy !== 1'b1 || sar_done !== 1'b0) begin failures++; $display("FAIL hold: Q=%h busy=%b done=%b expected %h/1/0", Q, busy, sar_done, q_trial); end
    end
    hold = 1'b0;
    wait_done(n);
    check_sar(n + 36, 70);
  endtask

  task automatic test_restart();
    int n;
    model_init(); track_evals(3);
    start = 1'b1; hold = 1'b1; tick(); start = 1'b0; hold = 1'b0;
    checks++; if (Q !== 10'h000 || busy !== 1'b1) begin failures++; $display("FAIL restart_trk: Q=%h busy=%b expected 000/1", Q, busy); end
    repeat (31) tick();
    pulse_start();
    checks++; if (Q !== 10'h000 || busy !== 1'b1) begin failures++; $display("FAIL restart_sar: Q=%h busy=%b expected 000/1", Q, busy); end
    wait_done(n);
    check_sar(n, 50);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      target = $urandom_range(0, (1 << CODE_W) - 1);
      pulse_start(); wait_done(n);
      check_sar(n, 50);
      model_init(); track_evals(4);
    end
  endtask

  initial begin
    test_reset();
    test_sar_track();
    test_saturation();
    test_hold();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
